// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// ALU operation codes, opcode/function constants and the instruction class.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // One-hot instruction class; all zero means the instruction is illegal.
    typedef struct packed {
        logic ralu;
        logic ialu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } iclass_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational instruction decode reproducing the single-cycle control table:
// instruction class, ALU operation, shift/sign-extend/rt-destination selects.
module mc_cu_decode
    import mc_cu_pkg::*;
#(
    parameter bit EXT_ISA = 1'b0
) (
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output iclass_t    o_cls,
    output logic [3:0] o_aluc,
    output logic       o_shift,
    output logic       o_sext,
    output logic       o_regrt,
    output logic       o_illegal
);

    // Decode op/func into class and single-cycle control fields.
    always_comb begin
        o_cls     = '0;
        o_aluc    = ALU_ADD;
        o_shift   = 1'b0;
        o_sext    = 1'b0;
        o_regrt   = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_func)
                    FN_ADD: begin o_cls.ralu = 1'b1; o_aluc = ALU_ADD; end
                    FN_SUB: begin o_cls.ralu = 1'b1; o_aluc = ALU_SUB; end
                    FN_AND: begin o_cls.ralu = 1'b1; o_aluc = ALU_AND; end
                    FN_OR:  begin o_cls.ralu = 1'b1; o_aluc = ALU_OR;  end
                    FN_XOR: begin o_cls.ralu = 1'b1; o_aluc = ALU_XOR; end
                    FN_SLL: begin o_cls.ralu = 1'b1; o_aluc = ALU_SLL; o_shift = 1'b1; end
                    FN_SRL: begin o_cls.ralu = 1'b1; o_aluc = ALU_SRL; o_shift = 1'b1; end
                    FN_SRA: begin o_cls.ralu = 1'b1; o_aluc = ALU_SRA; o_shift = 1'b1; end
                    FN_JR:  begin o_cls.jr   = 1'b1; end
                    FN_SLT: begin
                        if (EXT_ISA) begin
                            o_cls.ralu = 1'b1;
                            o_aluc     = ALU_SLT;
                        end else begin
                            o_illegal  = 1'b1;
                        end
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin o_cls.ialu = 1'b1; o_aluc = ALU_ADD; o_sext = 1'b1; o_regrt = 1'b1; end
            OP_ANDI: begin o_cls.ialu = 1'b1; o_aluc = ALU_AND; o_regrt = 1'b1; end
            OP_ORI:  begin o_cls.ialu = 1'b1; o_aluc = ALU_OR;  o_regrt = 1'b1; end
            OP_XORI: begin o_cls.ialu = 1'b1; o_aluc = ALU_XOR; o_regrt = 1'b1; end
            OP_LUI:  begin o_cls.ialu = 1'b1; o_aluc = ALU_LUI; o_regrt = 1'b1; end
            OP_LW:   begin o_cls.lw   = 1'b1; o_aluc = ALU_ADD; o_sext = 1'b1; o_regrt = 1'b1; end
            OP_SW:   begin o_cls.sw   = 1'b1; o_aluc = ALU_ADD; o_sext = 1'b1; end
            OP_BEQ:  begin o_cls.beq  = 1'b1; o_aluc = ALU_SUB; o_sext = 1'b1; end
            OP_BNE:  begin o_cls.bne  = 1'b1; o_aluc = ALU_SUB; o_sext = 1'b1; end
            OP_J:    begin o_cls.j    = 1'b1; end
            OP_JAL:  begin o_cls.jal  = 1'b1; end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer, per-state datapath
// controls, optional memory wait states and a retired-instruction counter.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter bit EXT_ISA  = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_rdy,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic [3:0]       aluc,
    output logic             shift,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             sext,
    output logic [1:0]       pcsource,
    output logic             jal,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    logic [CNT_W-1:0] r_instret;

    state_t      w_next;
    logic        w_retire;
    logic        w_rdy;
    iclass_t     w_cls;
    logic [3:0]  w_dec_aluc;
    logic        w_dec_shift;
    logic        w_dec_sext;
    logic        w_dec_regrt;
    logic        w_dec_illegal;

    logic        w_wpc, w_wir, w_wmem, w_wreg, w_iord, w_regrt, w_m2reg;
    logic [3:0]  w_aluc;
    logic        w_shift, w_alusrca, w_sext, w_jal, w_illegal;
    logic [1:0]  w_alusrcb, w_pcsource;

    mc_cu_decode #(
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_cls     (w_cls),
        .o_aluc    (w_dec_aluc),
        .o_shift   (w_dec_shift),
        .o_sext    (w_dec_sext),
        .o_regrt   (w_dec_regrt),
        .o_illegal (w_dec_illegal)
    );

    // Without wait states the memory is assumed to finish in one cycle.
    assign w_rdy = (MEM_WAIT != 0) ? mem_rdy : 1'b1;

    // Next-state, retire and per-state datapath control decode.
    always_comb begin
        w_next     = S_IF;
        w_retire   = 1'b0;
        w_wpc      = 1'b0;
        w_wir      = 1'b0;
        w_wmem     = 1'b0;
        w_wreg     = 1'b0;
        w_iord     = 1'b0;
        w_regrt    = 1'b0;
        w_m2reg    = 1'b0;
        w_aluc     = ALU_ADD;
        w_shift    = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_sext     = 1'b0;
        w_pcsource = 2'b00;
        w_jal      = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_IF: begin
                w_alusrcb = 2'b01;
                w_wir     = w_rdy;
                w_wpc     = w_rdy;
                if (w_rdy) begin
                    w_next = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                // Branch target PC + (sext imm << 2) is computed here speculatively.
                w_alusrcb = 2'b11;
                w_sext    = 1'b1;
                if (w_cls.j) begin
                    w_wpc      = 1'b1;
                    w_pcsource = 2'b11;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_cls.jal) begin
                    w_wpc      = 1'b1;
                    w_pcsource = 2'b11;
                    w_wreg     = 1'b1;
                    w_jal      = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_cls.jr) begin
                    w_wpc      = 1'b1;
                    w_pcsource = 2'b10;
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_dec_illegal) begin
                    w_illegal  = 1'b1;
                    w_next     = S_IF;
                end else begin
                    w_next     = S_EXE;
                end
            end
            S_EXE: begin
                w_alusrca = 1'b1;
                w_aluc    = w_dec_aluc;
                w_shift   = w_dec_shift;
                w_sext    = w_dec_sext;
                if (w_cls.beq || w_cls.bne) begin
                    w_alusrcb  = 2'b00;
                    w_pcsource = 2'b01;
                    w_wpc      = (w_cls.beq & z) | (w_cls.bne & ~z);
                    w_retire   = 1'b1;
                    w_next     = S_IF;
                end else if (w_cls.ralu) begin
                    w_alusrcb  = 2'b00;
                    w_next     = S_WB;
                end else if (w_cls.ialu) begin
                    w_alusrcb  = 2'b10;
                    w_regrt    = 1'b1;
                    w_next     = S_WB;
                end else if (w_cls.lw || w_cls.sw) begin
                    w_alusrcb  = 2'b10;
                    w_sext     = 1'b1;
                    w_aluc     = ALU_ADD;
                    w_next     = S_MEM;
                end else begin
                    w_next     = S_IF;
                end
            end
            S_MEM: begin
                w_iord = 1'b1;
                if (w_cls.sw) begin
                    w_wmem = 1'b1;
                    if (w_rdy) begin
                        w_retire = 1'b1;
                        w_next   = S_IF;
                    end else begin
                        w_next   = S_MEM;
                    end
                end else if (w_cls.lw) begin
                    if (w_rdy) begin
                        w_next = S_WB;
                    end else begin
                        w_next = S_MEM;
                    end
                end else begin
                    w_next = S_IF;
                end
            end
            S_WB: begin
                w_wreg   = 1'b1;
                w_regrt  = w_dec_regrt;
                w_m2reg  = w_cls.lw;
                w_retire = 1'b1;
                w_next   = S_IF;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // State register and retired-instruction counter with synchronous reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_IF;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_instret <= r_instret;
            end
        end
    end

    // Holding reset squashes every output, including writes of an in-flight instruction.
    assign wpc      = resetn ? w_wpc      : 1'b0;
    assign wir      = resetn ? w_wir      : 1'b0;
    assign wmem     = resetn ? w_wmem     : 1'b0;
    assign wreg     = resetn ? w_wreg     : 1'b0;
    assign iord     = resetn ? w_iord     : 1'b0;
    assign regrt    = resetn ? w_regrt    : 1'b0;
    assign m2reg    = resetn ? w_m2reg    : 1'b0;
    assign aluc     = resetn ? w_aluc     : 4'b0000;
    assign shift    = resetn ? w_shift    : 1'b0;
    assign alusrca  = resetn ? w_alusrca  : 1'b0;
    assign alusrcb  = resetn ? w_alusrcb  : 2'b00;
    assign sext     = resetn ? w_sext     : 1'b0;
    assign pcsource = resetn ? w_pcsource : 2'b00;
    assign jal      = resetn ? w_jal      : 1'b0;
    assign illegal  = resetn ? w_illegal  : 1'b0;
    assign state    = resetn ? r_state    : 3'd0;
    assign instret  = resetn ? r_instret  : {CNT_W{1'b0}};

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: two configurations share the inputs; the idle one is
// held in reset. Expected per-cycle controls come from an instruction-level model.
module tb_mc_cu;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9, K_SLT = 10;

    typedef struct packed {
        logic [2:0]  state;
        logic        wpc, wir, wmem, wreg, iord, regrt, m2reg;
        logic [3:0]  aluc;
        logic        shift, alusrca;
        logic [1:0]  alusrcb;
        logic        sext;
        logic [1:0]  pcsource;
        logic        jal, illegal;
        logic [15:0] instret;
    } rec_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
        logic [3:0] kind;
        logic [3:0] aluc;
        logic       shift;
        logic       sext;
    } ins_t;

    logic clock = 1'b0;
    logic resetn_a, resetn_b;
    logic [5:0] op, func;
    logic z, mem_rdy;

    logic a_wpc, a_wir, a_wmem, a_wreg, a_iord, a_regrt, a_m2reg, a_shift, a_alusrca, a_sext, a_jal, a_illegal;
    logic [3:0] a_aluc;
    logic [1:0] a_alusrcb, a_pcsource;
    logic [2:0] a_state;
    logic [15:0] a_instret;
    logic b_wpc, b_wir, b_wmem, b_wreg, b_iord, b_regrt, b_m2reg, b_shift, b_alusrca, b_sext, b_jal, b_illegal;
    logic [3:0] b_aluc;
    logic [1:0] b_alusrcb, b_pcsource;
    logic [2:0] b_state;
    logic [1:0] b_instret;

    int checks = 0;
    int errors = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    rec_t qa[$];
    rec_t qb[$];
    ins_t tbl[0:22];

    always #5 clock = ~clock;

    mc_cu #(.MEM_WAIT(1), .EXT_ISA(1'b0), .CNT_W(16)) dut_a (
        .clock(clock), .resetn(resetn_a), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(a_wpc), .wir(a_wir), .wmem(a_wmem), .wreg(a_wreg), .iord(a_iord), .regrt(a_regrt),
        .m2reg(a_m2reg), .aluc(a_aluc), .shift(a_shift), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
        .sext(a_sext), .pcsource(a_pcsource), .jal(a_jal), .state(a_state), .illegal(a_illegal),
        .instret(a_instret));

    mc_cu #(.MEM_WAIT(0), .EXT_ISA(1'b1), .CNT_W(2)) dut_b (
        .clock(clock), .resetn(resetn_b), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(b_wpc), .wir(b_wir), .wmem(b_wmem), .wreg(b_wreg), .iord(b_iord), .regrt(b_regrt),
        .m2reg(b_m2reg), .aluc(b_aluc), .shift(b_shift), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
        .sext(b_sext), .pcsource(b_pcsource), .jal(b_jal), .state(b_state), .illegal(b_illegal),
        .instret(b_instret));

    rec_t act_a, act_b;
    assign act_a = {a_state, a_wpc, a_wir, a_wmem, a_wreg, a_iord, a_regrt, a_m2reg, a_aluc,
                    a_shift, a_alusrca, a_alusrcb, a_sext, a_pcsource, a_jal, a_illegal, a_instret};
    assign act_b = {b_state, b_wpc, b_wir, b_wmem, b_wreg, b_iord, b_regrt, b_m2reg, b_aluc,
                    b_shift, b_alusrca, b_alusrcb, b_sext, b_pcsource, b_jal, b_illegal, 14'd0, b_instret};

    // Monitor: compare each configuration's outputs against the queued expectation.
    always @(negedge clock) begin
        rec_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if (act_a !== e) begin
                errors++;
                $display("FAIL cycle_a t=%0t got %h expected %h", $time, act_a, e);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if (act_b !== e) begin
                errors++;
                $display("FAIL cycle_b t=%0t got %h expected %h", $time, act_b, e);
            end
        end
    end

    function automatic ins_t mk(logic [5:0] o, logic [5:0] f, int k, logic [3:0] a, logic sh, logic se);
        ins_t t;
        t.op = o; t.func = f; t.kind = 4'(k); t.aluc = a; t.shift = sh; t.sext = se;
        return t;
    endfunction

    // Controls expected in one phase of an instruction, straight from the state tables.
    function automatic rec_t model(ins_t e, int k, int st, logic zz, logic rdy, int cnt);
        rec_t r;
        r = '0;
        r.state = 3'(st);
        r.instret = 16'(cnt);
        case (st)
            0: begin r.alusrcb = 2'b01; r.wir = rdy; r.wpc = rdy; end
            1: begin
                r.alusrcb = 2'b11; r.sext = 1'b1;
                if (k == K_J) begin r.wpc = 1'b1; r.pcsource = 2'b11; end
                else if (k == K_JAL) begin r.wpc = 1'b1; r.pcsource = 2'b11; r.wreg = 1'b1; r.jal = 1'b1; end
                else if (k == K_JR) begin r.wpc = 1'b1; r.pcsource = 2'b10; end
                else if (k == K_ILL) r.illegal = 1'b1;
            end
            2: begin
                r.alusrca = 1'b1; r.aluc = e.aluc; r.shift = e.shift; r.sext = e.sext;
                if (k == K_BEQ || k == K_BNE) begin
                    r.pcsource = 2'b01;
                    r.wpc = (k == K_BEQ) ? zz : ~zz;
                end else if (k == K_I) begin
                    r.alusrcb = 2'b10; r.regrt = 1'b1;
                end else if (k == K_LW || k == K_SW) begin
                    r.alusrcb = 2'b10;
                end
            end
            3: begin r.iord = 1'b1; r.wmem = (k == K_SW); end
            4: begin r.wreg = 1'b1; r.regrt = (k == K_I || k == K_LW); r.m2reg = (k == K_LW); end
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick(input int sel, input ins_t e, input int k, input int st);
        rec_t ra, rb;
        ra = '0;
        rb = '0;
        if (sel == 0 && resetn_a) ra = model(e, k, st, z, mem_rdy, cnt_a);
        if (sel == 1 && resetn_b) rb = model(e, k, st, z, 1'b1, cnt_b);
        qa.push_back(ra);
        qb.push_back(rb);
        @(posedge clock);
        #1;
    endtask

    task automatic retire(input int sel);
        if (sel == 0) cnt_a = (cnt_a + 1) & 16'hffff;
        else cnt_b = (cnt_b + 1) & 3;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one whole instruction with the given stall counts (ignored without wait states).
    task automatic exec(input int sel, input int idx, input logic zz, input int ifst, input int memst);
        ins_t e;
        int k;
        bit mw;
        e = tbl[idx];
        mw = (sel == 0);
        k = (int'(e.kind) == K_SLT) ? ((sel == 1) ? K_R : K_ILL) : int'(e.kind);
        op = e.op;
        func = (e.op == 6'd0) ? e.func : 6'($urandom);
        if (!mw) begin ifst = 0; memst = 0; end
        for (int i = 0; i <= ifst; i++) begin
            z = 1'($urandom);
            mem_rdy = mw ? 1'(i == ifst) : 1'($urandom);
            tick(sel, e, k, 0);
        end
        z = 1'($urandom); mem_rdy = 1'($urandom);
        tick(sel, e, k, 1);
        if (k == K_J || k == K_JAL || k == K_JR) begin retire(sel); return; end
        if (k == K_ILL) return;
        z = zz; mem_rdy = 1'($urandom);
        tick(sel, e, k, 2);
        if (k == K_BEQ || k == K_BNE) begin retire(sel); return; end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= memst; i++) begin
                z = 1'($urandom);
                mem_rdy = mw ? 1'(i == memst) : 1'($urandom);
                tick(sel, e, k, 3);
            end
            if (k == K_SW) begin retire(sel); return; end
        end
        z = 1'($urandom); mem_rdy = 1'($urandom);
        tick(sel, e, k, 4);
        retire(sel);
    endtask

    initial begin
        tbl[0]  = mk(6'd0, 6'b100000, K_R, 4'b0000, 1'b0, 1'b0);
        tbl[1]  = mk(6'd0, 6'b100010, K_R, 4'b0100, 1'b0, 1'b0);
        tbl[2]  = mk(6'd0, 6'b100100, K_R, 4'b0001, 1'b0, 1'b0);
        tbl[3]  = mk(6'd0, 6'b100101, K_R, 4'b0101, 1'b0, 1'b0);
        tbl[4]  = mk(6'd0, 6'b100110, K_R, 4'b0010, 1'b0, 1'b0);
        tbl[5]  = mk(6'd0, 6'b000000, K_R, 4'b0011, 1'b1, 1'b0);
        tbl[6]  = mk(6'd0, 6'b000010, K_R, 4'b0111, 1'b1, 1'b0);
        tbl[7]  = mk(6'd0, 6'b000011, K_R, 4'b1111, 1'b1, 1'b0);
        tbl[8]  = mk(6'd0, 6'b001000, K_JR, 4'b0000, 1'b0, 1'b0);
        tbl[9]  = mk(6'd0, 6'b101010, K_SLT, 4'b1010, 1'b0, 1'b0);
        tbl[10] = mk(6'b001000, 6'd0, K_I, 4'b0000, 1'b0, 1'b1);
        tbl[11] = mk(6'b001100, 6'd0, K_I, 4'b0001, 1'b0, 1'b0);
        tbl[12] = mk(6'b001101, 6'd0, K_I, 4'b0101, 1'b0, 1'b0);
        tbl[13] = mk(6'b001110, 6'd0, K_I, 4'b0010, 1'b0, 1'b0);
        tbl[14] = mk(6'b001111, 6'd0, K_I, 4'b0110, 1'b0, 1'b0);
        tbl[15] = mk(6'b100011, 6'd0, K_LW, 4'b0000, 1'b0, 1'b1);
        tbl[16] = mk(6'b101011, 6'd0, K_SW, 4'b0000, 1'b0, 1'b1);
        tbl[17] = mk(6'b000100, 6'd0, K_BEQ, 4'b0100, 1'b0, 1'b1);
        tbl[18] = mk(6'b000101, 6'd0, K_BNE, 4'b0100, 1'b0, 1'b1);
        tbl[19] = mk(6'b000010, 6'd0, K_J, 4'b0000, 1'b0, 1'b0);
        tbl[20] = mk(6'b000011, 6'd0, K_JAL, 4'b0000, 1'b0, 1'b0);
        tbl[21] = mk(6'b111111, 6'd0, K_ILL, 4'b0000, 1'b0, 1'b0);
        tbl[22] = mk(6'd0, 6'b111111, K_ILL, 4'b0000, 1'b0, 1'b0);

        resetn_a = 1'b0; resetn_b = 1'b0;
        op = 6'd0; func = 6'd0; z = 1'b0; mem_rdy = 1'b0;
        @(posedge clock);
        #1;
        tick(0, tbl[0], K_R, 0);
        tick(0, tbl[0], K_R, 0);
        resetn_a = 1'b1;

        // sw caught in a stalled MEM state by reset: the store must be dropped.
        op = tbl[16].op; func = 6'($urandom); z = 1'b0; mem_rdy = 1'b1;
        tick(0, tbl[16], K_SW, 0);
        tick(0, tbl[16], K_SW, 1);
        tick(0, tbl[16], K_SW, 2);
        mem_rdy = 1'b0;
        tick(0, tbl[16], K_SW, 3);
        resetn_a = 1'b0;
        tick(0, tbl[16], K_SW, 3);
        tick(0, tbl[16], K_SW, 3);
        cnt_a = 0;
        resetn_a = 1'b1;
        chk("reset_state", int'(a_state), 0);
        chk("reset_instret", int'(a_instret), 0);

        exec(0, 15, 1'b0, 0, 3);
        chk("lw_instret", int'(a_instret), 1);
        exec(0, 17, 1'b1, 0, 0);
        exec(0, 18, 1'b1, 0, 0);
        exec(0, 20, 1'b0, 1, 0);
        chk("jal_instret", int'(a_instret), 4);
        exec(0, 9, 1'b0, 0, 0);
        chk("slt_illegal_instret", int'(a_instret), 4);
        for (int n = 0; n < 150; n++) begin
            exec(0, $urandom_range(0, 22), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("a_final_instret", int'(a_instret), cnt_a);

        resetn_a = 1'b0;
        resetn_b = 1'b1;
        cnt_b = 0;
        exec(1, 0, 1'b0, 0, 0);
        chk("add_instret", int'(b_instret), 1);
        exec(1, 9, 1'b0, 0, 0);
        resetn_b = 1'b0;
        tick(1, tbl[5], K_R, 0);
        cnt_b = 0;
        resetn_b = 1'b1;
        for (int n = 0; n < 5; n++) exec(1, 5, 1'b0, 0, 0);
        chk("nop_wrap_instret", int'(b_instret), 1);
        for (int n = 0; n < 150; n++) begin
            exec(1, $urandom_range(0, 22), 1'($urandom), 0, 0);
        end
        chk("b_final_instret", int'(b_instret), cnt_b);
        chk("queues_drained", qa.size() + qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
